ldtu_bsl_calib: RTL and testbench

Baseline calibration sequencer for the LiTe-DTU front end. On command it measures the pedestal of the gain_1 and gain_10 ADC channels and loads the 8-bit baseline values (`BSL_VAL_g01`, `BSL_VAL_g10`) consumed by the baseline-subtraction stage. It averages 2^LOG2_NAVG raw samples per channel through one shared accumulator, visiting the channels in turn. It then subtracts a safety margin, saturates the result and holds it until the next calibration. A manual mode lets the I2C register bank supply the values directly.

---
 rtl/ldtu_bsl_pkg.sv | 20 ++
 rtl/ldtu_bsl_mean.sv | 34 +++
 rtl/ldtu_bsl_calib.sv | 178 +++++++++++++++++
 tb/tb_ldtu_bsl_calib.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ldtu_bsl_pkg.sv
// Shared types and constants for the LiTe-DTU baseline calibration sequencer.
package ldtu_bsl_pkg;

  localparam int unsigned Nbits_12      = 12;
  localparam int unsigned Nbits_8       = 8;
  localparam int unsigned BSL_MAX       = 255;
  localparam int unsigned LOG2_NAVG_MAX = 6;
  localparam int unsigned CNT_W         = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACC_G01,
    ST_FIN_G01,
    ST_ACC_G10,
    ST_FIN_G10,
    ST_DONE
  } bsl_state_e;

endpackage

// File: rtl/ldtu_bsl_mean.sv
// Combinational mean -> margin subtract -> floor/saturate, shared by both gain channels.
module ldtu_bsl_mean #(
  parameter int unsigned Nbits_12  = 12,
  parameter int unsigned Nbits_8   = 8,
  parameter int unsigned LOG2_NAVG = 4,
  parameter int unsigned ACC_W     = Nbits_12 + LOG2_NAVG
) (
  input  logic [ACC_W-1:0]   acc_i,
  input  logic [3:0]         margin_i,
  output logic [Nbits_8-1:0] val_c_o,
  output logic               sat_c_o
);
  import ldtu_bsl_pkg::*;

  logic [Nbits_12-1:0] mean;
  logic [Nbits_12-1:0] rem;

  always_comb begin
    mean    = Nbits_12'(acc_i >> LOG2_NAVG);
    rem     = '0;
    val_c_o = '0;
    sat_c_o = 1'b0;
    if (mean > Nbits_12'(margin_i)) begin
      rem = mean - Nbits_12'(margin_i);
    end
    if (rem > Nbits_12'(BSL_MAX)) begin
      val_c_o = Nbits_8'(BSL_MAX);
      sat_c_o = 1'b1;
    end else begin
      val_c_o = rem[Nbits_8-1:0];
    end
  end

endmodule

// File: rtl/ldtu_bsl_calib.sv
// Baseline calibration sequencer: averages gain_1/gain_10 pedestals through one
// shared accumulator and loads the 8-bit baselines, with a manual override.
module ldtu_bsl_calib #(
  parameter int unsigned Nbits_12   = 12,
  parameter int unsigned Nbits_8    = 8,
  parameter int unsigned LOG2_NAVG  = 4,
  parameter int unsigned SETTLE_CYC = 8
) (
  input  logic                CLK,
  input  logic                rst_b,
  input  logic                calib_start,
  input  logic                calib_en_g01,
  input  logic                calib_en_g10,
  input  logic [Nbits_12-1:0] DATA12_g01,
  input  logic [Nbits_12-1:0] DATA12_g10,
  input  logic [1:0]          shift_gain_10,
  input  logic [3:0]          margin,
  input  logic                manual_mode,
  input  logic [Nbits_8-1:0]  BSL_MAN_g01,
  input  logic [Nbits_8-1:0]  BSL_MAN_g10,
  output logic [Nbits_8-1:0]  BSL_VAL_g01,
  output logic [Nbits_8-1:0]  BSL_VAL_g10,
  output logic                calib_busy,
  output logic                calib_done,
  output logic                sat_g01,
  output logic                sat_g10
);
  import ldtu_bsl_pkg::*;

  localparam int unsigned ACC_W = Nbits_12 + LOG2_NAVG;
  localparam int unsigned NAVG  = 1 << LOG2_NAVG;

  bsl_state_e          state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [Nbits_8-1:0]  bsl_g01_q, bsl_g01_d;
  logic [Nbits_8-1:0]  bsl_g10_q, bsl_g10_d;
  logic                sat_g01_q, sat_g01_d;
  logic                sat_g10_q, sat_g10_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [Nbits_12-1:0] smp_g10;
  logic [Nbits_8-1:0]  mean_val;
  logic                mean_sat;

  assign smp_g10 = DATA12_g10 >> shift_gain_10;

  ldtu_bsl_mean #(
    .Nbits_12  (Nbits_12),
    .Nbits_8   (Nbits_8),
    .LOG2_NAVG (LOG2_NAVG),
    .ACC_W     (ACC_W)
  ) u_mean (
    .acc_i    (acc_q),
    .margin_i (margin),
    .val_c_o  (mean_val),
    .sat_c_o  (mean_sat)
  );

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    bsl_g01_d = bsl_g01_q;
    bsl_g10_d = bsl_g10_q;
    sat_g01_d = sat_g01_q;
    sat_g10_d = sat_g10_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (calib_start && !manual_mode) begin
          state_d   = ST_SETTLE;
          acc_d     = '0;
          cnt_d     = '0;
          sat_g01_d = 1'b0;
          sat_g10_d = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_d = '0;
          if (calib_en_g01)      state_d = ST_ACC_G01;
          else if (calib_en_g10) state_d = ST_ACC_G10;
          else                   state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACC_G01: begin
        acc_d = acc_q + ACC_W'(DATA12_g01);
        if (cnt_q == CNT_W'(NAVG - 1)) begin
          state_d = ST_FIN_G01;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FIN_G01: begin
        bsl_g01_d = mean_val;
        sat_g01_d = sat_g01_q | mean_sat;
        acc_d     = '0;
        cnt_d     = '0;
        state_d   = calib_en_g10 ? ST_ACC_G10 : ST_DONE;
      end
      ST_ACC_G10: begin
        acc_d = acc_q + ACC_W'(smp_g10);
        if (cnt_q == CNT_W'(NAVG - 1)) begin
          state_d = ST_FIN_G10;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FIN_G10: begin
        bsl_g10_d = mean_val;
        sat_g10_d = sat_g10_q | mean_sat;
        acc_d     = '0;
        cnt_d     = '0;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Manual mode overrides everything: aborts any run and discards FIN writes
    if (manual_mode) begin
      state_d   = ST_IDLE;
      acc_d     = '0;
      cnt_d     = '0;
      bsl_g01_d = BSL_MAN_g01;
      bsl_g10_d = BSL_MAN_g10;
      sat_g01_d = sat_g01_q;
      sat_g10_d = sat_g10_q;
    end

    busy_d = (state_d inside {ST_SETTLE, ST_ACC_G01, ST_FIN_G01, ST_ACC_G10, ST_FIN_G10});
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      bsl_g01_q <= '0;
      bsl_g10_q <= '0;
      sat_g01_q <= 1'b0;
      sat_g10_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      bsl_g01_q <= bsl_g01_d;
      bsl_g10_q <= bsl_g10_d;
      sat_g01_q <= sat_g01_d;
      sat_g10_q <= sat_g10_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign BSL_VAL_g01 = bsl_g01_q;
  assign BSL_VAL_g10 = bsl_g10_q;
  assign sat_g01     = sat_g01_q;
  assign sat_g10     = sat_g10_q;
  assign calib_busy  = busy_q;
  assign calib_done  = done_q;

endmodule

// File: tb/tb_ldtu_bsl_calib.sv
// Directed self-checking bench for ldtu_bsl_calib (default S=8, N=16).
module tb_ldtu_bsl_calib;

  logic        CLK = 1'b0;
  logic        rst_b = 1'b1;
  logic        calib_start = 1'b0;
  logic        calib_en_g01 = 1'b1;
  logic        calib_en_g10 = 1'b1;
  logic [11:0] DATA12_g01 = '0;
  logic [11:0] DATA12_g10 = '0;
  logic [1:0]  shift_gain_10 = '0;
  logic [3:0]  margin = '0;
  logic        manual_mode = 1'b0;
  logic [7:0]  BSL_MAN_g01 = '0;
  logic [7:0]  BSL_MAN_g10 = '0;
  logic [7:0]  BSL_VAL_g01;
  logic [7:0]  BSL_VAL_g10;
  logic        calib_busy;
  logic        calib_done;
  logic        sat_g01;
  logic        sat_g10;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  ldtu_bsl_calib dut (
    .CLK           (CLK),
    .rst_b         (rst_b),
    .calib_start   (calib_start),
    .calib_en_g01  (calib_en_g01),
    .calib_en_g10  (calib_en_g10),
    .DATA12_g01    (DATA12_g01),
    .DATA12_g10    (DATA12_g10),
    .shift_gain_10 (shift_gain_10),
    .margin        (margin),
    .manual_mode   (manual_mode),
    .BSL_MAN_g01   (BSL_MAN_g01),
    .BSL_MAN_g10   (BSL_MAN_g10),
    .BSL_VAL_g01   (BSL_VAL_g01),
    .BSL_VAL_g10   (BSL_VAL_g10),
    .calib_busy    (calib_busy),
    .calib_done    (calib_done),
    .sat_g01       (sat_g01),
    .sat_g10       (sat_g10)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one
  task automatic adv(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Returns 1 ns after edge 0 (the edge that samples calib_start)
  task automatic start_run();
    calib_start = 1'b1;
    adv(1);
    calib_start = 1'b0;
  endtask

  initial begin
    logic seen_done;

    #1 rst_b = 1'b0;
    #1;
    chk("rst_bsl01", 32'(BSL_VAL_g01), 32'd0);
    chk("rst_bsl10", 32'(BSL_VAL_g10), 32'd0);
    chk("rst_busy",  32'(calib_busy),  32'd0);
    chk("rst_done",  32'(calib_done),  32'd0);
    chk("rst_sat",   32'({sat_g01, sat_g10}), 32'd0);
    adv(2);
    rst_b = 1'b1;
    adv(2);

    // Nominal run: 100 / 40, margin 2
    DATA12_g01 = 12'd100; DATA12_g10 = 12'd40; margin = 4'd2;
    start_run();
    chk("t1_busy_e0", 32'(calib_busy), 32'd1);
    chk("t1_done_e0", 32'(calib_done), 32'd0);
    adv(24);
    chk("t1_bsl01_e24", 32'(BSL_VAL_g01), 32'd0);
    adv(1);
    chk("t1_bsl01_e25", 32'(BSL_VAL_g01), 32'd98);
    adv(16);
    chk("t1_bsl10_e41", 32'(BSL_VAL_g10), 32'd0);
    chk("t1_done_e41",  32'(calib_done),  32'd0);
    adv(1);
    chk("t1_bsl10_e42", 32'(BSL_VAL_g10), 32'd38);
    chk("t1_done_e42",  32'(calib_done),  32'd1);
    chk("t1_busy_e42",  32'(calib_busy),  32'd0);
    chk("t1_sat_e42",   32'({sat_g01, sat_g10}), 32'd0);
    adv(1);
    chk("t1_done_e43",  32'(calib_done),  32'd0);

    // Saturation on both channels (4000>>2 = 1000)
    DATA12_g01 = 12'd300; DATA12_g10 = 12'd4000; shift_gain_10 = 2'd2; margin = 4'd0;
    start_run();
    adv(42);
    chk("t2_bsl01", 32'(BSL_VAL_g01), 32'd255);
    chk("t2_bsl10", 32'(BSL_VAL_g10), 32'd255);
    chk("t2_sat01", 32'(sat_g01), 32'd1);
    chk("t2_sat10", 32'(sat_g10), 32'd1);
    chk("t2_done",  32'(calib_done), 32'd1);
    adv(1);
    shift_gain_10 = 2'd0;

    // Truncating mean of alternating 10/11, g01 only
    calib_en_g10 = 1'b0; DATA12_g01 = 12'd11;
    start_run();
    chk("t3_sat01_clr", 32'(sat_g01), 32'd0);
    chk("t3_sat10_clr", 32'(sat_g10), 32'd0);
    for (int i = 1; i <= 25; i++) begin
      DATA12_g01 = (i % 2 == 1) ? 12'd10 : 12'd11;
      adv(1);
    end
    chk("t3_bsl01", 32'(BSL_VAL_g01), 32'd10);
    chk("t3_done",  32'(calib_done),  32'd1);
    chk("t3_bsl10_kept", 32'(BSL_VAL_g10), 32'd255);
    adv(1);

    // Floor at zero
    DATA12_g01 = 12'd1; margin = 4'd5;
    start_run();
    adv(25);
    chk("t4_bsl01", 32'(BSL_VAL_g01), 32'd0);
    chk("t4_sat01", 32'(sat_g01), 32'd0);
    chk("t4_done",  32'(calib_done), 32'd1);
    adv(1);

    // Preload g01 = 77
    DATA12_g01 = 12'd77; margin = 4'd0;
    start_run();
    adv(25);
    chk("t5_pre_bsl01", 32'(BSL_VAL_g01), 32'd77);
    adv(1);

    // g10 only, with an ignored second start while busy
    calib_en_g01 = 1'b0; calib_en_g10 = 1'b1; DATA12_g10 = 12'd40;
    start_run();
    adv(4);
    calib_start = 1'b1;
    adv(1);
    calib_start = 1'b0;
    adv(19);
    chk("t5_done_e24", 32'(calib_done), 32'd0);
    adv(1);
    chk("t5_done_e25", 32'(calib_done), 32'd1);
    chk("t5_bsl10",    32'(BSL_VAL_g10), 32'd40);
    chk("t5_bsl01_kept", 32'(BSL_VAL_g01), 32'd77);
    adv(1);
    chk("t5_done_e26", 32'(calib_done), 32'd0);
    adv(1);
    chk("t5_no_requeue", 32'(calib_busy), 32'd0);

    // Neither channel enabled: DONE straight after SETTLE
    calib_en_g10 = 1'b0;
    start_run();
    adv(7);
    chk("t6_busy_e7", 32'(calib_busy), 32'd1);
    chk("t6_done_e7", 32'(calib_done), 32'd0);
    adv(1);
    chk("t6_done_e8", 32'(calib_done), 32'd1);
    adv(2);

    // Manual-mode abort at edge 15
    calib_en_g01 = 1'b1; calib_en_g10 = 1'b1;
    DATA12_g01 = 12'd100; DATA12_g10 = 12'd40; margin = 4'd2;
    BSL_MAN_g01 = 8'h12; BSL_MAN_g10 = 8'h34;
    start_run();
    adv(14);
    manual_mode = 1'b1;
    adv(1);
    chk("t7_bsl01_man", 32'(BSL_VAL_g01), 32'h12);
    chk("t7_bsl10_man", 32'(BSL_VAL_g10), 32'h34);
    chk("t7_busy",      32'(calib_busy),  32'd0);
    chk("t7_done",      32'(calib_done),  32'd0);
    manual_mode = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      adv(1);
      if (calib_done) seen_done = 1'b1;
    end
    chk("t7_no_done",   32'(seen_done),   32'd0);
    chk("t7_bsl01_hold", 32'(BSL_VAL_g01), 32'h12);

    // Asynchronous reset mid ACC_G10
    DATA12_g01 = 12'd300; margin = 4'd0;
    start_run();
    adv(30);
    chk("t8_pre_bsl01", 32'(BSL_VAL_g01), 32'd255);
    chk("t8_pre_sat01", 32'(sat_g01), 32'd1);
    chk("t8_pre_busy",  32'(calib_busy), 32'd1);
    #2 rst_b = 1'b0;
    #1;
    chk("t8_bsl01", 32'(BSL_VAL_g01), 32'd0);
    chk("t8_bsl10", 32'(BSL_VAL_g10), 32'd0);
    chk("t8_sat",   32'({sat_g01, sat_g10}), 32'd0);
    chk("t8_busy",  32'(calib_busy), 32'd0);
    chk("t8_done",  32'(calib_done), 32'd0);
    adv(1);
    rst_b = 1'b1;
    adv(3);
    chk("t8_idle_after", 32'(calib_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
